// File: rtl/lib_arbiter_pkg.sv
// Shared types and helpers for the pixel-level req/gnt arbiter hierarchy.
// Holds the pixel requester state encoding and the popcount used by drop accounting.
package lib_arbiter_pkg;

  typedef enum logic [1:0] {
    PIX_IDLE    = 2'd0,
    PIX_REQ     = 2'd1,
    PIX_REFRACT = 2'd2
  } pix_state_t;

  localparam int POP_IN_W  = 64;
  localparam int POP_OUT_W = 7;

  // Callers zero-extend narrower vectors to POP_IN_W bits.
  function automatic logic [POP_OUT_W-1:0] popcount(input logic [POP_IN_W-1:0] v);
    logic [POP_OUT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < POP_IN_W; i++) begin
      cnt = cnt + POP_OUT_W'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/pixel_req_cell.sv
// One pixel's request FSM: captures an event, holds req until granted, then
// blocks further events for a programmable refractory period.
module pixel_req_cell
  import lib_arbiter_pkg::*;
#(
  parameter int REFR_W = 4
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              enable_i,
  input  logic [REFR_W-1:0] refr_cycles_i,
  input  logic              evt_edge_i,
  input  logic              polarity_i,
  input  logic              gnt_i,
  output logic              req_o,
  output logic              req_d_o,
  output logic              pol_o,
  output logic              drop_o,
  output pix_state_t        state_o
);

  pix_state_t        state_q, state_d;
  logic [REFR_W-1:0] cnt_q, cnt_d;
  logic              pol_q, pol_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pol_d   = pol_q;
    drop_o  = 1'b0;
    case (state_q)
      PIX_IDLE: begin
        if (evt_edge_i && enable_i) begin
          state_d = PIX_REQ;
          pol_d   = polarity_i;
        end
      end
      PIX_REQ: begin
        // A grant arriving with a new edge still wins; the edge is lost.
        drop_o = evt_edge_i;
        if (gnt_i) begin
          if (refr_cycles_i == '0) begin
            state_d = PIX_IDLE;
          end else begin
            state_d = PIX_REFRACT;
            cnt_d   = refr_cycles_i;
          end
        end
      end
      PIX_REFRACT: begin
        drop_o = evt_edge_i;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q <= REFR_W'(1)) begin
          state_d = PIX_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = PIX_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= PIX_IDLE;
      cnt_q   <= '0;
      pol_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pol_q   <= pol_d;
    end
  end

  assign req_o   = (state_q == PIX_REQ);
  assign req_d_o = (state_d == PIX_REQ);
  assign pol_o   = pol_q;
  assign state_o = state_q;

endmodule

// File: rtl/pixel_event_requester.sv
// Pixel-side requester for the lowest arbiter level: edge-detects pixel events,
// keeps one request per pixel, counts lost events and flags protocol errors.
module pixel_event_requester
  import lib_arbiter_pkg::*;
#(
  parameter int Lvl_ROWS = 4,
  parameter int Lvl_COLS = 4,
  parameter int REFR_W   = 4,
  parameter int CNT_W    = 16
) (
  input  logic                               clk_i,
  input  logic                               reset_ni,
  input  logic                               enable_i,
  input  logic [REFR_W-1:0]                  refr_cycles_i,
  input  logic [Lvl_ROWS-1:0][Lvl_COLS-1:0]  event_i,
  input  logic [Lvl_ROWS-1:0][Lvl_COLS-1:0]  polarity_i,
  input  logic [Lvl_ROWS-1:0][Lvl_COLS-1:0]  gnt_i,
  output logic [Lvl_ROWS-1:0][Lvl_COLS-1:0]  req_o,
  output logic [Lvl_ROWS-1:0][Lvl_COLS-1:0]  pol_o,
  output logic                               busy_o,
  output logic [CNT_W-1:0]                   drop_cnt_o,
  output logic                               err_o,
  output pix_state_t [Lvl_ROWS*Lvl_COLS-1:0] dbg_state_o
);

  localparam int NPIX  = Lvl_ROWS * Lvl_COLS;
  localparam int SUM_W = CNT_W + 1;

  logic [NPIX-1:0]      event_q, event_d;
  logic [NPIX-1:0]      evt_edge, gnt_flat, pol_flat, req_flat, req_next, drop_vec;
  logic                 busy_q, busy_d;
  logic                 err_q, err_d;
  logic [CNT_W-1:0]     drop_cnt_q, drop_cnt_d;
  logic [SUM_W-1:0]     drop_sum;
  logic [POP_OUT_W-1:0] drop_pop, gnt_pop;

  assign event_d  = event_i;
  assign gnt_flat = gnt_i;
  assign evt_edge = event_d & ~event_q;

  for (genvar p = 0; p < NPIX; p++) begin : g_pix
    pixel_req_cell #(
      .REFR_W (REFR_W)
    ) u_cell (
      .clk_i         (clk_i),
      .reset_ni      (reset_ni),
      .enable_i      (enable_i),
      .refr_cycles_i (refr_cycles_i),
      .evt_edge_i    (evt_edge[p]),
      .polarity_i    (polarity_i[p / Lvl_COLS][p % Lvl_COLS]),
      .gnt_i         (gnt_flat[p]),
      .req_o         (req_flat[p]),
      .req_d_o       (req_next[p]),
      .pol_o         (pol_flat[p]),
      .drop_o        (drop_vec[p]),
      .state_o       (dbg_state_o[p])
    );
  end

  always_comb begin
    drop_pop   = popcount(POP_IN_W'(drop_vec));
    gnt_pop    = popcount(POP_IN_W'(gnt_flat));
    drop_sum   = {1'b0, drop_cnt_q} + SUM_W'(drop_pop);
    // Saturate rather than wrap so a stuck-busy array stays visible.
    drop_cnt_d = drop_sum[CNT_W] ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
    err_d      = err_q | (|(gnt_flat & ~req_flat)) | (gnt_pop > POP_OUT_W'(1));
    busy_d     = |req_next;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      event_q    <= '0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      event_q    <= event_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign req_o      = req_flat;
  assign pol_o      = pol_flat;
  assign busy_o     = busy_q;
  assign err_o      = err_q;
  assign drop_cnt_o = drop_cnt_q;

endmodule
